// File: rtl/cell_revealer.sv
// Minesweeper reveal engine: opens and flags cells, flood-fills zero regions
// through a coordinate stack, and reports a lost or won game.
module cell_revealer #(
  parameter int unsigned MAX_CELL_WIDTH  = 30,
  parameter int unsigned MAX_CELL_HEIGHT = 16,
  localparam int unsigned CELL_COUNT = MAX_CELL_WIDTH * MAX_CELL_HEIGHT,
  localparam int unsigned MINES_W    = $clog2(CELL_COUNT / 4),
  localparam int unsigned X_W        = $clog2(MAX_CELL_WIDTH),
  localparam int unsigned Y_W        = $clog2(MAX_CELL_HEIGHT),
  localparam int unsigned CNT_W      = $clog2(CELL_COUNT + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [3:0]         game_field_i [MAX_CELL_WIDTH][MAX_CELL_HEIGHT],
  input  logic               field_valid_i,
  input  logic [X_W-1:0]     field_width_i,
  input  logic [Y_W-1:0]     field_height_i,
  input  logic [MINES_W-1:0] mines_count_i,
  input  logic               new_game_i,
  input  logic               open_req_i,
  input  logic               flag_toggle_i,
  input  logic [X_W-1:0]     cell_x_i,
  input  logic [Y_W-1:0]     cell_y_i,
  output logic               revealed_o [MAX_CELL_WIDTH][MAX_CELL_HEIGHT],
  output logic               flagged_o  [MAX_CELL_WIDTH][MAX_CELL_HEIGHT],
  output logic [CNT_W-1:0]   revealed_count_o,
  output logic               busy_o,
  output logic               mine_hit_o,
  output logic               game_won_o
);

  localparam int unsigned XE_W   = X_W + 1;
  localparam int unsigned YE_W   = Y_W + 1;
  localparam int unsigned PW     = X_W + Y_W;
  localparam int unsigned PROD_W = X_W + Y_W;
  localparam int unsigned CMP_W  = ((PROD_W > CNT_W) ? PROD_W : CNT_W) + 1;

  typedef enum logic [2:0] {IDLE, POP, NEIGHBOURS, CHECK_WIN, LOST, WON} state_t;

  state_t           r_state, w_state_nxt;
  logic             r_revealed [MAX_CELL_WIDTH][MAX_CELL_HEIGHT];
  logic             r_flagged  [MAX_CELL_WIDTH][MAX_CELL_HEIGHT];
  logic [PW-1:0]    r_stack    [CELL_COUNT];
  logic [CNT_W-1:0] r_count, r_sp;
  logic [X_W-1:0]   r_cur_x;
  logic [Y_W-1:0]   r_cur_y;
  logic [2:0]       r_nidx;

  logic             w_tgt_in, w_tgt_rev, w_tgt_flag;
  logic [3:0]       w_tgt_val;
  logic             w_dx_m, w_dx_p, w_dy_m, w_dy_p;
  logic [XE_W-1:0]  w_nx_ext;
  logic [YE_W-1:0]  w_ny_ext;
  logic [X_W-1:0]   w_nx;
  logic [Y_W-1:0]   w_ny;
  logic             w_nb_in, w_nb_ok;
  logic [3:0]       w_nb_val;
  logic [PW-1:0]    w_top;
  logic [PROD_W-1:0] w_area;
  logic [CMP_W-1:0] w_goal;
  logic             w_open_tgt, w_flag_tgt, w_push_tgt, w_pop, w_nb_open, w_nb_push;

  // Request target qualification
  assign w_tgt_in   = (cell_x_i < field_width_i) && (cell_y_i < field_height_i) &&
                      ({1'b0, cell_x_i} < XE_W'(MAX_CELL_WIDTH)) &&
                      ({1'b0, cell_y_i} < YE_W'(MAX_CELL_HEIGHT));
  assign w_tgt_rev  = r_revealed[cell_x_i][cell_y_i];
  assign w_tgt_flag = r_flagged[cell_x_i][cell_y_i];
  assign w_tgt_val  = game_field_i[cell_x_i][cell_y_i];

  // Neighbour offset table, scanned row by row from the upper-left
  always_comb begin
    w_dx_m = 1'b0;
    w_dx_p = 1'b0;
    w_dy_m = 1'b0;
    w_dy_p = 1'b0;
    case (r_nidx)
      3'd0:    begin w_dx_m = 1'b1; w_dy_m = 1'b1; end
      3'd1:    w_dy_m = 1'b1;
      3'd2:    begin w_dx_p = 1'b1; w_dy_m = 1'b1; end
      3'd3:    w_dx_m = 1'b1;
      3'd4:    w_dx_p = 1'b1;
      3'd5:    begin w_dx_m = 1'b1; w_dy_p = 1'b1; end
      3'd6:    w_dy_p = 1'b1;
      default: begin w_dx_p = 1'b1; w_dy_p = 1'b1; end
    endcase
  end

  assign w_nx_ext = w_dx_m ? ({1'b0, r_cur_x} - XE_W'(1)) :
                    w_dx_p ? ({1'b0, r_cur_x} + XE_W'(1)) : {1'b0, r_cur_x};
  assign w_ny_ext = w_dy_m ? ({1'b0, r_cur_y} - YE_W'(1)) :
                    w_dy_p ? ({1'b0, r_cur_y} + YE_W'(1)) : {1'b0, r_cur_y};
  assign w_nx     = w_nx_ext[X_W-1:0];
  assign w_ny     = w_ny_ext[Y_W-1:0];
  assign w_nb_in  = !(w_dx_m && (r_cur_x == '0)) && !(w_dy_m && (r_cur_y == '0)) &&
                    (w_nx_ext < XE_W'(field_width_i)) && (w_ny_ext < YE_W'(field_height_i)) &&
                    (w_nx_ext < XE_W'(MAX_CELL_WIDTH)) && (w_ny_ext < YE_W'(MAX_CELL_HEIGHT));
  assign w_nb_val = game_field_i[w_nx][w_ny];
  assign w_nb_ok  = w_nb_in && !r_revealed[w_nx][w_ny] && !r_flagged[w_nx][w_ny] &&
                    (w_nb_val != 4'd9);

  assign w_top  = r_stack[r_sp - CNT_W'(1)];
  assign w_area = PROD_W'(field_width_i) * PROD_W'(field_height_i);
  assign w_goal = CMP_W'(w_area) - CMP_W'(mines_count_i);

  always_ff @(posedge clk) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_open_tgt  = 1'b0;
    w_flag_tgt  = 1'b0;
    w_push_tgt  = 1'b0;
    w_pop       = 1'b0;
    w_nb_open   = 1'b0;
    w_nb_push   = 1'b0;
    if (new_game_i) begin
      w_state_nxt = IDLE;
    end else begin
      case (r_state)
        IDLE: begin
          if (field_valid_i && open_req_i) begin
            if (w_tgt_in && !w_tgt_rev && !w_tgt_flag) begin
              w_open_tgt = 1'b1;
              if (w_tgt_val == 4'd9) begin
                w_state_nxt = LOST;
              end else if (w_tgt_val == 4'd0) begin
                w_push_tgt  = 1'b1;
                w_state_nxt = POP;
              end else begin
                w_state_nxt = CHECK_WIN;
              end
            end
          end else if (flag_toggle_i && !open_req_i && w_tgt_in && !w_tgt_rev) begin
            w_flag_tgt = 1'b1;
          end
        end
        POP: begin
          if (r_sp == '0) begin
            w_state_nxt = CHECK_WIN;
          end else begin
            w_pop       = 1'b1;
            w_state_nxt = NEIGHBOURS;
          end
        end
        NEIGHBOURS: begin
          if (w_nb_ok) begin
            w_nb_open = 1'b1;
            w_nb_push = (w_nb_val == 4'd0);
          end
          if (r_nidx == 3'd7) w_state_nxt = POP;
        end
        CHECK_WIN: w_state_nxt = (CMP_W'(r_count) == w_goal) ? WON : IDLE;
        default: ;
      endcase
    end
  end

  // Play state: cell bits, counters, stack pointer and flood cursor
  always_ff @(posedge clk) begin
    if (!rst || new_game_i) begin
      r_revealed <= '{default: '0};
      r_flagged  <= '{default: '0};
      r_count    <= '0;
      r_sp       <= '0;
      r_cur_x    <= '0;
      r_cur_y    <= '0;
      r_nidx     <= '0;
    end else begin
      if (w_open_tgt) r_revealed[cell_x_i][cell_y_i] <= 1'b1;
      if (w_nb_open)  r_revealed[w_nx][w_ny] <= 1'b1;
      if (w_flag_tgt) r_flagged[cell_x_i][cell_y_i] <= !w_tgt_flag;
      if (w_open_tgt || w_nb_open) r_count <= r_count + CNT_W'(1);
      if (w_push_tgt || w_nb_push) r_sp <= r_sp + CNT_W'(1);
      else if (w_pop)              r_sp <= r_sp - CNT_W'(1);
      if (w_pop) begin
        {r_cur_x, r_cur_y} <= w_top;
        r_nidx             <= '0;
      end else if (r_state == NEIGHBOURS) begin
        r_nidx <= r_nidx + 3'd1;
      end
    end
  end

  // Stack storage needs no reset; only the pointer defines its contents
  always_ff @(posedge clk) begin
    if (w_push_tgt)     r_stack[r_sp] <= {cell_x_i, cell_y_i};
    else if (w_nb_push) r_stack[r_sp] <= {w_nx, w_ny};
  end

  assign revealed_o       = r_revealed;
  assign flagged_o        = r_flagged;
  assign revealed_count_o = r_count;
  assign busy_o           = (r_state == POP) || (r_state == NEIGHBOURS) || (r_state == CHECK_WIN);
  assign mine_hit_o       = (r_state == LOST);
  assign game_won_o       = (r_state == WON);

endmodule
